// File: rtl/ufm_pkg.sv
// ufm_pkg: shared types and helpers for the ufm_seq shift-add multiplier.
//   state_t  - control FSM encoding (IDLE, CALC, DONE)
//   RES_MULT - result width is RES_MULT * operand width
//   clog2    - bits needed to hold a value, used to size the step counter
package ufm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int RES_MULT = 2;

  // Returns the number of bits needed to encode 0 .. value-1.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/ufm_absval.sv
// ufm_absval: combinational sign/magnitude split of one operand.
//   value     in  WIDTH  raw operand
//   signed_en in  1      treat value as two's complement
//   mag       out WIDTH  unsigned magnitude (|-2^(WIDTH-1)| = 2^(WIDTH-1) fits unsigned)
//   neg       out 1      operand was negative
module ufm_absval
  import ufm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic             signed_en,
  output logic [WIDTH-1:0] mag,
  output logic             neg
);

  always_comb begin
    neg = signed_en & value[WIDTH-1];
    mag = neg ? -value : value;
  end

endmodule

// File: rtl/ufm_seq.sv
// ufm_seq: radix-2 shift-add multiplier with valid/ready handshake.
//   clk, rst          clock and synchronous active-high reset
//   en                global stall: 0 holds every register and blocks handshakes
//   in_valid/in_ready operand handshake (accept = in_valid & in_ready)
//   signed_mode       operands are two's complement (only when SIGNED_EN != 0)
//   multiplicant      operand A, multiplier operand B
//   out_valid/rd      result handshake (read = out_valid & rd & en)
//   result            2*WIDTH product, held until read
//   busy              high while iterating
module ufm_seq
  import ufm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicant,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 rd,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy
);

  localparam int RES_W = RES_MULT * WIDTH;
  localparam int CNT_W = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic SIGNED_OK = (SIGNED_EN != 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [RES_W-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             neg_q, neg_d;
  logic [RES_W-1:0] result_q, result_d;

  logic             op_signed;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             a_neg, b_neg;
  logic             accept;
  logic             zero_op;
  logic [RES_W-1:0] acc_sum;

  assign op_signed = signed_mode & SIGNED_OK;

  ufm_absval #(.WIDTH(WIDTH)) u_abs_a (
    .value     (multiplicant),
    .signed_en (op_signed),
    .mag       (a_mag),
    .neg       (a_neg)
  );

  ufm_absval #(.WIDTH(WIDTH)) u_abs_b (
    .value     (multiplier),
    .signed_en (op_signed),
    .mag       (b_mag),
    .neg       (b_neg)
  );

  // in_ready also opens in DONE when the consumer reads, so a new operation
  // can start on the same edge the previous result leaves.
  assign in_ready  = en & ((state_q == IDLE) | ((state_q == DONE) & rd));
  assign accept    = in_valid & in_ready;
  assign zero_op   = (multiplicant == '0) | (multiplier == '0);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC);
  assign result    = result_q;

  // Next-state and datapath. Instead of indexing B_mag[count] and shifting A
  // by count, B is shifted right and A left each step; bit 0 of the B shifter
  // is the current multiplier bit and the A shifter is already aligned.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    neg_d    = neg_q;
    result_d = result_q;
    acc_sum  = acc_q + (b_sh_q[0] ? a_sh_q : '0);

    if (en) begin
      unique case (state_q)
        CALC: begin
          acc_d   = acc_sum;
          a_sh_d  = a_sh_q << 1;
          b_sh_d  = b_sh_q >> 1;
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_STEP) begin
            state_d  = DONE;
            result_d = neg_q ? -acc_sum : acc_sum;
          end
        end
        DONE: begin
          if (rd) state_d = IDLE;
        end
        default: ;
      endcase

      // Accept overrides the DONE->IDLE exit for back-to-back operation.
      if (accept) begin
        a_sh_d  = {{(RES_W - WIDTH){1'b0}}, a_mag};
        b_sh_d  = b_mag;
        neg_d   = a_neg ^ b_neg;
        acc_d   = '0;
        count_d = '0;
        if (zero_op) begin
          state_d  = DONE;
          result_d = '0;
        end else begin
          state_d  = CALC;
        end
      end
    end
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_ufm_seq.sv
// tb_ufm_seq: scoreboard bench for ufm_seq.
//   dut3  : WIDTH=3, signed_mode tied low by stimulus (unsigned paths, stall,
//           handshake, reset abort)
//   dut8s : WIDTH=8, SIGNED_EN=1
//   dut8u : WIDTH=8, SIGNED_EN=0, driven with the same inputs as dut8s
// Stimulus pushes hand-computed products into per-DUT queues; monitors pop
// and compare whenever a result is read.
module tb_ufm_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       en3, iv3, sm3, rd3;
  logic [2:0] a3, b3;
  logic       ir3, ov3, busy3;
  logic [5:0] res3;

  logic        en8, iv8, sm8, rd8;
  logic [7:0]  a8, b8;
  logic        ir8s, ov8s, busy8s;
  logic        ir8u, ov8u, busy8u;
  logic [15:0] res8s, res8u;

  int errors = 0;
  int checks = 0;

  logic [15:0] q3[$];
  logic [15:0] q8s[$];
  logic [15:0] q8u[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] exp_s;
    logic [15:0] exp_u;
  } vec8_t;

  vec8_t v8[6];

  ufm_seq #(.WIDTH(3), .SIGNED_EN(1)) dut3 (
    .clk(clk), .rst(rst), .en(en3), .in_valid(iv3), .in_ready(ir3),
    .signed_mode(sm3), .multiplicant(a3), .multiplier(b3),
    .out_valid(ov3), .rd(rd3), .result(res3), .busy(busy3)
  );

  ufm_seq #(.WIDTH(8), .SIGNED_EN(1)) dut8s (
    .clk(clk), .rst(rst), .en(en8), .in_valid(iv8), .in_ready(ir8s),
    .signed_mode(sm8), .multiplicant(a8), .multiplier(b8),
    .out_valid(ov8s), .rd(rd8), .result(res8s), .busy(busy8s)
  );

  ufm_seq #(.WIDTH(8), .SIGNED_EN(0)) dut8u (
    .clk(clk), .rst(rst), .en(en8), .in_valid(iv8), .in_ready(ir8u),
    .signed_mode(sm8), .multiplicant(a8), .multiplier(b8),
    .out_valid(ov8u), .rd(rd8), .result(res8u), .busy(busy8u)
  );

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name, input string detail);
    checks++;
    errors++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  // Result monitors: a read happens on the next rising edge when these
  // conditions hold at the falling edge.
  always @(negedge clk) begin
    if (!rst && en3 && rd3 && ov3) begin
      if (q3.size() == 0)
        flag_fail("res3_unexpected", $sformatf("got 0x%0h expected no result", res3));
      else
        check_output("res3", 32'(res3), 32'(q3.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && en8 && rd8 && ov8s) begin
      if (q8s.size() == 0)
        flag_fail("res8s_unexpected", $sformatf("got 0x%0h expected no result", res8s));
      else
        check_output("res8s", 32'(res8s), 32'(q8s.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && en8 && rd8 && ov8u) begin
      if (q8u.size() == 0)
        flag_fail("res8u_unexpected", $sformatf("got 0x%0h expected no result", res8u));
      else
        check_output("res8u", 32'(res8u), 32'(q8u.pop_front()));
    end
  end

  // Present operands until accepted; returns just after the accept edge with
  // in_valid dropped and the operand bus scrambled.
  task automatic apply_stimulus3(input logic [2:0] a, input logic [2:0] b,
                                 input logic [15:0] exp);
    int n;
    iv3 = 1'b1; sm3 = 1'b0; a3 = a; b3 = b;
    n = 0;
    while (!ir3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ir3) flag_fail("accept3_timeout", "in_ready never rose");
    else q3.push_back(exp);
    @(posedge clk);
    #1;
    iv3 = 1'b0; a3 = ~a; b3 = ~b;
  endtask

  task automatic apply_stimulus8(input vec8_t v);
    int n;
    iv8 = 1'b1; sm8 = v.sm; a8 = v.a; b8 = v.b;
    n = 0;
    while (!ir8s && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ir8s) flag_fail("accept8_timeout", "in_ready never rose");
    else begin
      q8s.push_back(v.exp_s);
      q8u.push_back(v.exp_u);
    end
    @(posedge clk);
    #1;
    iv8 = 1'b0; a8 = ~v.a; b8 = ~v.b; sm8 = ~v.sm;
  endtask

  // Counts falling edges after the accept edge until out_valid is seen.
  task automatic wait_valid3(output int lat);
    lat = 0;
    @(negedge clk);
    while (!ov3 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!ov3) flag_fail("ov3_timeout", "out_valid never rose");
  endtask

  task automatic wait_valid8(output int lat);
    lat = 0;
    @(negedge clk);
    while (!ov8s && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!ov8s) flag_fail("ov8_timeout", "out_valid never rose");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;

    // Signed results: -3*5=-15, -128*-128=16384, 127*-127=-16129, -1*-1=1.
    // Unsigned view of the same bits: 253*5, 128*128, 127*129, 255*255.
    v8[0] = '{a: 8'hFD, b: 8'h05, sm: 1'b1, exp_s: 16'hFFF1, exp_u: 16'h04F1};
    v8[1] = '{a: 8'h80, b: 8'h80, sm: 1'b1, exp_s: 16'h4000, exp_u: 16'h4000};
    v8[2] = '{a: 8'h00, b: 8'h7F, sm: 1'b1, exp_s: 16'h0000, exp_u: 16'h0000};
    v8[3] = '{a: 8'h7F, b: 8'h81, sm: 1'b1, exp_s: 16'hC0FF, exp_u: 16'h3FFF};
    v8[4] = '{a: 8'h05, b: 8'hFF, sm: 1'b0, exp_s: 16'h04FB, exp_u: 16'h04FB};
    v8[5] = '{a: 8'hFF, b: 8'hFF, sm: 1'b1, exp_s: 16'h0001, exp_u: 16'hFE01};

    rst = 1'b1;
    en3 = 1'b1; iv3 = 1'b0; sm3 = 1'b0; rd3 = 1'b1; a3 = '0; b3 = '0;
    en8 = 1'b1; iv8 = 1'b0; sm8 = 1'b0; rd8 = 1'b1; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check_output("rst_ov3", 32'(ov3), 32'd0);
    check_output("rst_res3", 32'(res3), 32'd0);
    check_output("rst_busy3", 32'(busy3), 32'd0);
    check_output("rst_ir3", 32'(ir3), 32'd1);
    check_output("rst_ov8s", 32'(ov8s), 32'd0);
    check_output("rst_res8s", 32'(res8s), 32'd0);
    check_output("rst_ir8u", 32'(ir8u), 32'd1);

    // Unsigned WIDTH=3 products, second one back-to-back with the read.
    apply_stimulus3(3'd2, 3'd5, 16'd10);
    wait_valid3(lat);
    check_output("lat3_a", 32'(lat), 32'd3);
    apply_stimulus3(3'd2, 3'd7, 16'd14);
    wait_valid3(lat);
    check_output("lat3_b", 32'(lat), 32'd3);

    // Stall for four edges after the first CALC step.
    apply_stimulus3(3'd6, 3'd7, 16'd42);
    @(posedge clk);
    #1;
    en3 = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_output("stall_busy3", 32'(busy3), 32'd1);
      check_output("stall_ov3", 32'(ov3), 32'd0);
      check_output("stall_ir3", 32'(ir3), 32'd0);
      check_output("stall_res3", 32'(res3), 32'd14);
      @(posedge clk);
    end
    #1;
    en3 = 1'b1;
    wait_valid3(lat);
    check_output("lat3_stall", 32'(lat), 32'd2);

    // Consumer holds off for five cycles, then reads while a new op arrives.
    @(posedge clk);
    #1;
    rd3 = 1'b0;
    apply_stimulus3(3'd5, 3'd3, 16'd15);
    wait_valid3(lat);
    check_output("lat3_hold", 32'(lat), 32'd3);
    repeat (5) begin
      @(negedge clk);
      check_output("hold_ov3", 32'(ov3), 32'd1);
      check_output("hold_res3", 32'(res3), 32'd15);
      check_output("hold_ir3", 32'(ir3), 32'd0);
    end
    @(posedge clk);
    #1;
    rd3 = 1'b1;
    apply_stimulus3(3'd3, 3'd3, 16'd9);
    check_output("b2b_busy3", 32'(busy3), 32'd1);
    check_output("b2b_ov3", 32'(ov3), 32'd0);
    wait_valid3(lat);
    check_output("lat3_b2b", 32'(lat), 32'd3);

    // WIDTH=8 signed and unsigned instances, including the zero fast path.
    for (int i = 0; i < 6; i++) begin
      apply_stimulus8(v8[i]);
      wait_valid8(lat);
      if (v8[i].a == 8'h00 || v8[i].b == 8'h00) begin
        check_output("lat8_zero", 32'(lat), 32'd0);
        check_output("zero_busy8", 32'(busy8s), 32'd0);
      end else begin
        check_output("lat8", 32'(lat), 32'd8);
      end
      check_output("ov8u_align", 32'(ov8u), 32'd1);
    end

    // Reset one cycle into CALC; the aborted product must never appear.
    apply_stimulus3(3'd7, 3'd7, 16'd49);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q3.delete();
    check_output("abort_ov3", 32'(ov3), 32'd0);
    check_output("abort_res3", 32'(res3), 32'd0);
    check_output("abort_ir3", 32'(ir3), 32'd1);
    check_output("abort_busy3", 32'(busy3), 32'd0);
    repeat (12) @(negedge clk);
    check_output("abort_quiet_ov3", 32'(ov3), 32'd0);

    repeat (3) @(negedge clk);
    check_output("q3_drained", 32'(q3.size()), 32'd0);
    check_output("q8s_drained", 32'(q8s.size()), 32'd0);
    check_output("q8u_drained", 32'(q8u.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
